// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: bundles the write-back queue's producer handshake,
// register-file write port, forwarding lookup and occupancy signals.
//   slave  : seen by the queue (regfile_wb_queue)
//   master : seen by the producer / register file / decode side
// Producer : in_valid, in_ready, in_rd, in_data
// Drain    : wb_en, RegWrite, RD, WriteData
// Lookup   : RS1, RS2, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
// Status   : count
interface regfile_wb_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 5
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rd;
   logic [DATA_W-1:0] in_data;
   logic              wb_en;
   logic              RegWrite;
   logic [ADDR_W-1:0] RD;
   logic [DATA_W-1:0] WriteData;
   logic [ADDR_W-1:0] RS1;
   logic [ADDR_W-1:0] RS2;
   logic              fwd1_hit;
   logic              fwd2_hit;
   logic [DATA_W-1:0] fwd1_data;
   logic [DATA_W-1:0] fwd2_data;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  in_valid, in_rd, in_data, wb_en, RS1, RS2,
      output in_ready, RegWrite, RD, WriteData,
             fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
   );

   modport master (
      output in_valid, in_rd, in_data, wb_en, RS1, RS2,
      input  in_ready, RegWrite, RD, WriteData,
             fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
   );
endinterface

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back buffer in front of the register file.
// Accepts result writes over valid/ready, queues them in a circular FIFO and
// drains at most one per cycle onto the register-file write port. Optionally
// reports the youngest queued value matching RS1/RS2 for forwarding.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : regfile_wb_queue_if.slave (handshake, drain, lookup, count)
// Build option: define REGFILE_WB_FWD_EN to build the lookup comparators;
// otherwise fwd*_hit / fwd*_data are tied to 0.
module regfile_wb_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   regfile_wb_queue_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] rd_q   [DEPTH];
   logic [ADDR_W-1:0] rd_d   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic not_empty;
   logic push;
   logic pop;

   // Ready is masked by reset so the producer sees 0 while it is held.
   assign not_empty     = (count_q != '0);
   assign bus.in_ready  = reset & (count_q < CNT_W'(DEPTH));
   assign bus.RegWrite  = bus.wb_en & not_empty;
   assign bus.RD        = not_empty ? rd_q[head_q]   : '0;
   assign bus.WriteData = not_empty ? data_q[head_q] : '0;
   assign bus.count     = count_q;

   // Writes to x0 complete the handshake but are dropped.
   assign push = bus.in_valid & bus.in_ready & (bus.in_rd != '0);
   assign pop  = bus.RegWrite;

   // Next-state: enqueue at tail, dequeue at head, track occupancy.
   always_comb begin
      rd_d    = rd_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         rd_d[tail_q]   = bus.in_rd;
         data_d[tail_q] = bus.in_data;
         tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; queued entries are discarded on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

`ifdef REGFILE_WB_FWD_EN
   logic [PTR_W-1:0]  idx;
   logic              fwd1_hit_c, fwd2_hit_c;
   logic [DATA_W-1:0] fwd1_data_c, fwd2_data_c;

   // Walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      idx         = '0;
      fwd1_hit_c  = 1'b0;
      fwd2_hit_c  = 1'b0;
      fwd1_data_c = '0;
      fwd2_data_c = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            if ((bus.RS1 != '0) && (rd_q[idx] == bus.RS1)) begin
               fwd1_hit_c  = 1'b1;
               fwd1_data_c = data_q[idx];
            end
            if ((bus.RS2 != '0) && (rd_q[idx] == bus.RS2)) begin
               fwd2_hit_c  = 1'b1;
               fwd2_data_c = data_q[idx];
            end
         end
      end
   end

   assign bus.fwd1_hit  = fwd1_hit_c;
   assign bus.fwd2_hit  = fwd2_hit_c;
   assign bus.fwd1_data = fwd1_data_c;
   assign bus.fwd2_data = fwd2_data_c;
`else
   // Lookup addresses are ignored when forwarding is not built.
   logic unused_rs;
   assign unused_rs     = ^{bus.RS1, bus.RS2};
   assign bus.fwd1_hit  = 1'b0;
   assign bus.fwd2_hit  = 1'b0;
   assign bus.fwd1_data = '0;
   assign bus.fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed-vector bench for regfile_wb_queue.
// Drives inputs 1 time unit after each rising edge and samples outputs 1 time
// unit later, well clear of the next edge.
module tb_regfile_wb_queue;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 5;

   logic clk;
   logic reset;

   int unsigned n_total;
   int unsigned n_pass;

   regfile_wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

   regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
      bus_if.in_valid = v;
      bus_if.in_rd    = rd;
      bus_if.in_data  = d;
   endtask

   initial begin
      logic              fwd_on;
      logic [63:0]       exp_b;
      n_total = 0;
      n_pass  = 0;
`ifdef REGFILE_WB_FWD_EN
      fwd_on = 1'b1;
`else
      fwd_on = 1'b0;
`endif
      exp_b = fwd_on ? 64'hB : 64'h0;

      reset = 1'b0;
      drive(1'b0, '0, '0);
      bus_if.wb_en = 1'b1;
      bus_if.RS1   = '0;
      bus_if.RS2   = '0;
      #2;
      // Reset state
      check("rst_ready",    64'(bus_if.in_ready),  64'd0);
      check("rst_count",    64'(bus_if.count),     64'd0);
      check("rst_regwrite", 64'(bus_if.RegWrite),  64'd0);
      check("rst_rd",       64'(bus_if.RD),        64'd0);
      check("rst_wdata",    64'(bus_if.WriteData), 64'd0);
      step();
      step();
      reset = 1'b1;
      #1;
      check("post_rst_ready", 64'(bus_if.in_ready), 64'd1);

      // Single write, one-cycle latency to the register file
      drive(1'b1, 5'd11, 64'h1);
      #1;
      check("t1_no_comb_path", 64'(bus_if.RegWrite), 64'd0);
      step();
      drive(1'b0, '0, '0);
      #1;
      check("t1_regwrite", 64'(bus_if.RegWrite),  64'd1);
      check("t1_rd",       64'(bus_if.RD),        64'd11);
      check("t1_wdata",    64'(bus_if.WriteData), 64'h1);
      check("t1_count",    64'(bus_if.count),     64'd1);
      step();
      check("t1_count_after", 64'(bus_if.count),    64'd0);
      check("t1_rw_after",    64'(bus_if.RegWrite), 64'd0);

      // Fill with wb_en=0, then drain in order
      bus_if.wb_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ADDR_W'(3 + i), 64'(32'h30 + 32'h10 * i));
         step();
      end
      drive(1'b1, 5'd7, 64'h70);
      #1;
      check("t2_count_full", 64'(bus_if.count),    64'd4);
      check("t2_ready_full", 64'(bus_if.in_ready), 64'd0);
      check("t2_frozen",     64'(bus_if.RegWrite), 64'd0);
      step();
      check("t2_fifth_rej",  64'(bus_if.count),    64'd4);
      drive(1'b0, '0, '0);
      bus_if.wb_en = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("t2_drain_rw",    64'(bus_if.RegWrite),  64'd1);
         check("t2_drain_rd",    64'(bus_if.RD),        64'(3 + i));
         check("t2_drain_wdata", 64'(bus_if.WriteData), 64'(32'h30 + 32'h10 * i));
         step();
         if (i == 0) check("t2_ready_after_pop", 64'(bus_if.in_ready), 64'd1);
      end
      check("t2_empty",    64'(bus_if.count),    64'd0);
      check("t2_empty_rw", 64'(bus_if.RegWrite), 64'd0);

      // Write to x0 is accepted and discarded
      drive(1'b1, 5'd0, 64'hFF);
      #1;
      check("t3_ready", 64'(bus_if.in_ready), 64'd1);
      step();
      drive(1'b0, '0, '0);
      #1;
      check("t3_count", 64'(bus_if.count),    64'd0);
      check("t3_rw",    64'(bus_if.RegWrite), 64'd0);

      // Forwarding picks the youngest match; current in_data is not visible
      bus_if.wb_en = 1'b0;
      drive(1'b1, 5'd7, 64'hA);
      step();
      drive(1'b1, 5'd7, 64'hB);
      step();
      drive(1'b1, 5'd9, 64'hC);
      bus_if.RS1 = 5'd7;
      bus_if.RS2 = 5'd0;
      #1;
      check("t4_count",     64'(bus_if.count),     64'd2);
      check("t4_fwd1_hit",  64'(bus_if.fwd1_hit),  64'(fwd_on));
      check("t4_fwd1_data", 64'(bus_if.fwd1_data), exp_b);
      check("t4_fwd2_hit",  64'(bus_if.fwd2_hit),  64'd0);
      check("t4_fwd2_data", 64'(bus_if.fwd2_data), 64'd0);
      bus_if.RS2 = 5'd9;
      #1;
      check("t4_no_inflight_hit", 64'(bus_if.fwd2_hit), 64'd0);
      drive(1'b0, '0, '0);
      bus_if.RS2   = 5'd0;
      bus_if.wb_en = 1'b1;
      #1;
      check("t4_drain_a", 64'(bus_if.WriteData), 64'hA);
      check("t4_head_fwd", 64'(bus_if.fwd1_data), exp_b);
      step();
      check("t4_drain_b", 64'(bus_if.WriteData), 64'hB);
      check("t4_last_fwd", 64'(bus_if.fwd1_hit), 64'(fwd_on));
      step();
      check("t4_empty",    64'(bus_if.count),    64'd0);
      check("t4_fwd_gone", 64'(bus_if.fwd1_hit), 64'd0);
      bus_if.RS1 = 5'd0;

      // Streaming push+pop, one per cycle, across pointer wrap
      for (int i = 0; i <= 10; i++) begin
         if (i < 10) drive(1'b1, ADDR_W'(i + 1), 64'(32'h100 + i));
         else        drive(1'b0, '0, '0);
         #1;
         check("t5_ready", 64'(bus_if.in_ready), 64'd1);
         if (i > 0) begin
            check("t5_rw",    64'(bus_if.RegWrite),  64'd1);
            check("t5_rd",    64'(bus_if.RD),        64'(i));
            check("t5_wdata", 64'(bus_if.WriteData), 64'(32'h100 + i - 1));
            check("t5_count", 64'(bus_if.count),     64'd1);
         end
         step();
      end
      check("t5_empty", 64'(bus_if.count), 64'd0);

      // Asynchronous reset while entries are waiting to drain
      bus_if.wb_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ADDR_W'(20 + i), 64'(32'h200 + i));
         step();
      end
      drive(1'b0, '0, '0);
      bus_if.RS1   = 5'd20;
      bus_if.wb_en = 1'b1;
      #1;
      check("t6_count3", 64'(bus_if.count),    64'd3);
      check("t6_rw_pre", 64'(bus_if.RegWrite), 64'd1);
      #1;
      reset = 1'b0;
      #1;
      check("t6_rst_rw",    64'(bus_if.RegWrite),  64'd0);
      check("t6_rst_rd",    64'(bus_if.RD),        64'd0);
      check("t6_rst_wdata", 64'(bus_if.WriteData), 64'd0);
      check("t6_rst_count", 64'(bus_if.count),     64'd0);
      check("t6_rst_ready", 64'(bus_if.in_ready),  64'd0);
      check("t6_rst_fwd",   64'(bus_if.fwd1_hit),  64'd0);
      step();
      #1;
      reset = 1'b1;
      #1;
      check("t6_rel_count", 64'(bus_if.count),    64'd0);
      check("t6_rel_ready", 64'(bus_if.in_ready), 64'd1);
      check("t6_rel_rw",    64'(bus_if.RegWrite), 64'd0);
      step();
      check("t6_no_stale", 64'(bus_if.RegWrite), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
